// File: rtl/timer_irq_ctrl_if.sv
// Core-side and timer-side signal bundle for timer_irq_ctrl.
// The slave modport is the controller; the master modport is whoever drives it.
interface timer_irq_ctrl_if #(
    parameter int MISS_W = 8
);
    logic              tmr_irq;
    logic              start;
    logic              stop;
    logic              cmp_wr;
    logic [31:0]       cmp_in;
    logic              irq_en;
    logic              irq_ack;
    logic              irq_done;
    logic              tmr_enable;
    logic [31:0]       cmp_out;
    logic              irq_req;
    logic              pending;
    logic              in_service;
    logic [MISS_W-1:0] miss_cnt;

    modport slave (
        input  tmr_irq, start, stop, cmp_wr, cmp_in, irq_en, irq_ack, irq_done,
        output tmr_enable, cmp_out, irq_req, pending, in_service, miss_cnt
    );

    modport master (
        output tmr_irq, start, stop, cmp_wr, cmp_in, irq_en, irq_ack, irq_done,
        input  tmr_enable, cmp_out, irq_req, pending, in_service, miss_cnt
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer run/compare control plus a one-deep interrupt request/service handshake
// with a saturating counter of events dropped while one was already pending.
module timer_irq_ctrl #(
    parameter int MISS_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    timer_irq_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              run_q, run_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              pending_q, pending_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              tmr_irq_q;

    logic irq_event;
    logic ack_fire;

    assign irq_event = bus.tmr_irq & ~tmr_irq_q;
    assign ack_fire  = (state_q == ST_REQ) & bus.irq_ack;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        state_d   = state_q;
        run_d     = run_q;
        cmp_d     = cmp_q;
        pending_d = pending_q;
        miss_d    = miss_q;

        if (bus.stop) begin
            run_d = 1'b0;
        end else if (bus.start) begin
            run_d = 1'b1;
        end

        if (bus.cmp_wr) begin
            cmp_d = bus.cmp_in;
        end

        // An event landing on the ack edge refills the slot the ack just emptied.
        if (ack_fire) begin
            pending_d = irq_event;
        end else if (irq_event) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (!(&miss_q)) begin
                miss_d = miss_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:    if (pending_q && bus.irq_en) state_d = ST_REQ;
            ST_REQ:     if (bus.irq_ack)             state_d = ST_SERVICE;
            ST_SERVICE: if (bus.irq_done)            state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            cmp_q     <= '0;
            pending_q <= 1'b0;
            miss_q    <= '0;
            tmr_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            cmp_q     <= cmp_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            tmr_irq_q <= bus.tmr_irq;
        end
    end

    assign bus.tmr_enable = run_q;
    assign bus.cmp_out    = cmp_q;
    assign bus.irq_req    = (state_q == ST_REQ);
    assign bus.pending    = pending_q;
    assign bus.in_service = (state_q == ST_SERVICE);
    assign bus.miss_cnt   = miss_q;
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench: two controllers (8-bit and 2-bit miss counter) share one stimulus
// stream; a reference model queues expected outputs, a monitor compares after each edge.
module tb_timer_irq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        reset;
        logic        tmr_irq;
        logic        start;
        logic        stop;
        logic        cmp_wr;
        logic [31:0] cmp_in;
        logic        irq_en;
        logic        irq_ack;
        logic        irq_done;
    } stim_t;

    typedef struct packed {
        logic        en;
        logic [31:0] cmp;
        logic        req;
        logic        pend;
        logic        svc;
        logic [7:0]  miss8;
        logic [1:0]  miss2;
    } exp_t;

    typedef enum {PH_IDLE, PH_ASKING, PH_SERVING} phase_t;

    timer_irq_ctrl_if #(.MISS_W(8)) if8 ();
    timer_irq_ctrl_if #(.MISS_W(2)) if2 ();

    timer_irq_ctrl #(.MISS_W(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
    timer_irq_ctrl #(.MISS_W(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    stim_t cur = '0;
    assign reset        = cur.reset;
    assign if8.tmr_irq  = cur.tmr_irq;
    assign if8.start    = cur.start;
    assign if8.stop     = cur.stop;
    assign if8.cmp_wr   = cur.cmp_wr;
    assign if8.cmp_in   = cur.cmp_in;
    assign if8.irq_en   = cur.irq_en;
    assign if8.irq_ack  = cur.irq_ack;
    assign if8.irq_done = cur.irq_done;
    assign if2.tmr_irq  = cur.tmr_irq;
    assign if2.start    = cur.start;
    assign if2.stop     = cur.stop;
    assign if2.cmp_wr   = cur.cmp_wr;
    assign if2.cmp_in   = cur.cmp_in;
    assign if2.irq_en   = cur.irq_en;
    assign if2.irq_ack  = cur.irq_ack;
    assign if2.irq_done = cur.irq_done;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference model state
    bit          m_run, m_prev, m_pending;
    bit [31:0]   m_cmp;
    phase_t      m_phase;
    int          m_miss8, m_miss2;

    bit en_lvl  = 1'b0;
    bit tmr_lvl = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
        end
    endtask

    function automatic stim_t base();
        stim_t s = '0;
        s.irq_en  = en_lvl;
        s.tmr_irq = tmr_lvl;
        return s;
    endfunction

    function automatic void model(input stim_t s);
        bit ev, had_pending;
        if (s.reset) begin
            m_run = 0; m_prev = 0; m_pending = 0; m_cmp = 0;
            m_phase = PH_IDLE; m_miss8 = 0; m_miss2 = 0;
            return;
        end
        ev          = s.tmr_irq && !m_prev;
        m_prev      = s.tmr_irq;
        had_pending = m_pending;
        if (s.stop) m_run = 0;
        else if (s.start) m_run = 1;
        if (s.cmp_wr) m_cmp = s.cmp_in;
        if (m_phase == PH_ASKING && s.irq_ack) begin
            m_pending = ev;
        end else if (ev) begin
            if (m_pending) begin
                m_miss8 = (m_miss8 < 255) ? m_miss8 + 1 : 255;
                m_miss2 = (m_miss2 < 3) ? m_miss2 + 1 : 3;
            end else begin
                m_pending = 1;
            end
        end
        case (m_phase)
            PH_IDLE:    if (had_pending && s.irq_en) m_phase = PH_ASKING;
            PH_ASKING:  if (s.irq_ack) m_phase = PH_SERVING;
            PH_SERVING: if (s.irq_done) m_phase = PH_IDLE;
        endcase
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        cur = s;
        model(s);
        e.en    = m_run;
        e.cmp   = m_cmp;
        e.req   = (m_phase == PH_ASKING);
        e.pend  = m_pending;
        e.svc   = (m_phase == PH_SERVING);
        e.miss8 = 8'(m_miss8);
        e.miss2 = 2'(m_miss2);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(base());
    endtask

    task automatic pulse();
        stim_t s = base();
        s.tmr_irq = 1'b1;
        step(s);
        step(base());
    endtask

    task automatic ack();
        stim_t s = base();
        s.irq_ack = 1'b1;
        step(s);
    endtask

    task automatic done();
        stim_t s = base();
        s.irq_done = 1'b1;
        step(s);
    endtask

    task automatic do_reset(input int n);
        stim_t s = base();
        s.reset = 1'b1;
        for (int i = 0; i < n; i++) step(s);
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outs_w8",
                      64'({if8.tmr_enable, if8.cmp_out, if8.irq_req, if8.pending, if8.in_service, if8.miss_cnt}),
                      64'({e.en, e.cmp, e.req, e.pend, e.svc, e.miss8}));
                check("outs_w2",
                      64'({if2.tmr_enable, if2.cmp_out, if2.irq_req, if2.pending, if2.in_service, if2.miss_cnt}),
                      64'({e.en, e.cmp, e.req, e.pend, e.svc, e.miss2}));
            end
        end
    end

    initial begin
        stim_t s;
        do_reset(2);

        // Compare load and run control, including start+stop together
        s = base(); s.cmp_wr = 1; s.cmp_in = 32'h0000_0010; s.start = 1; step(s);
        idle(1);
        s = base(); s.stop = 1; step(s);
        s = base(); s.start = 1; step(s);
        s = base(); s.start = 1; s.stop = 1; step(s);

        // Basic request / ack / done
        en_lvl = 1;
        pulse();
        idle(1);
        ack();
        idle(1);
        done();
        idle(2);

        // Three events during service, then re-request via idle
        pulse(); idle(1); ack();
        pulse(); pulse(); pulse();
        done();
        idle(3);
        ack(); done(); idle(2);

        // Masked request, then unmask
        en_lvl = 0;
        pulse(); idle(3);
        en_lvl = 1;
        idle(2);
        ack();
        // Event coinciding with ack stays queued
        do_reset(1);
        pulse(); idle(1);
        s = base(); s.irq_ack = 1; s.tmr_irq = 1; step(s);
        idle(1); done(); idle(3); ack(); done(); idle(1);

        // Stray ack/done outside their states
        ack(); done(); idle(1);

        // Saturation and held level
        en_lvl = 0;
        pulse();
        for (int i = 0; i < 6; i++) pulse();
        tmr_lvl = 1; idle(10); tmr_lvl = 0; idle(2);

        // Reset overrides start, cmp_wr and tmr_irq
        s = base(); s.reset = 1; s.start = 1; s.cmp_wr = 1; s.cmp_in = 32'hdead_beef; s.tmr_irq = 1; step(s);
        s = base(); s.tmr_irq = 1; step(s);
        idle(1);

        // Reset during service with pending and miss_cnt=5
        do_reset(1);
        en_lvl = 1;
        pulse(); idle(1); ack();
        for (int i = 0; i < 6; i++) pulse();
        do_reset(1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) tmr_lvl = ~tmr_lvl;
            if ($urandom_range(0, 9) == 0) en_lvl = ~en_lvl;
            s = base();
            s.start    = ($urandom_range(0, 7) == 0);
            s.stop     = ($urandom_range(0, 7) == 0);
            s.cmp_wr   = ($urandom_range(0, 5) == 0);
            s.cmp_in   = $urandom;
            s.irq_ack  = ($urandom_range(0, 2) == 0);
            s.irq_done = ($urandom_range(0, 3) == 0);
            s.reset    = ($urandom_range(0, 99) == 0);
            step(s);
        end

        idle(2);
        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 SHALL have parameter MISS_W, default 8, width of missed-event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tmr_irq  input  1  compare-match flag from the 32-bit timer.
REQ-005 SHALL have port start  input  1  one-cycle request to run the timer.
REQ-006 SHALL have port stop  input  1  one-cycle request to halt the timer.
REQ-007 SHALL have port cmp_wr  input  1  load strobe for cmp_in.
REQ-008 SHALL have port cmp_in  input  32  new compare value.
REQ-009 SHALL have port irq_en  input  1  core-side interrupt enable mask.
REQ-010 SHALL have port irq_ack  input  1  core acknowledges request.
REQ-011 SHALL have port irq_done  input  1  core signals handler return.
REQ-012 SHALL have port tmr_enable  output  1  drives the timer enable.
REQ-013 SHALL have port cmp_out  output  32  registered compare value to the timer.
REQ-014 SHALL have port irq_req  output  1  interrupt request to the core.
REQ-015 SHALL have port pending  output  1  one event latched, not yet acknowledged.
REQ-016 SHALL have port in_service  output  1  handler active.
REQ-017 SHALL have port miss_cnt  output  MISS_W  count of dropped events.

Function
REQ-018 SHALL detect an event as a tmr_irq rising edge (registered previous value); a level held high SHALL count once.
REQ-019 SHALL set run register on start and clear it on stop; stop SHALL win if both are asserted; tmr_enable = run.
REQ-020 SHALL load cmp_out from cmp_in on cmp_wr, one-cycle latency, independent of FSM state.
REQ-021 SHALL implement FSM states IDLE, REQ, SERVICE, registered state.
REQ-022 SHALL move IDLE->REQ when pending=1 and irq_en=1; with irq_en=0 SHALL hold IDLE, pending kept.
REQ-023 SHALL drive irq_req=1 exactly while in REQ, registered, not combinational on inputs.
REQ-024 SHALL move REQ->SERVICE on irq_ack, clearing pending the same edge; irq_req SHALL hold until ack (irq_en drop in REQ does not retract it).
REQ-025 SHALL move SERVICE->IDLE on irq_done; in_service=1 exactly while in SERVICE.
REQ-026 SHALL ignore irq_ack outside REQ and irq_done outside SERVICE.
REQ-027 SHALL set pending on an event when pending=0; event with pending=1 SHALL increment miss_cnt instead.
REQ-028 Event coinciding with irq_ack in REQ SHALL leave pending=1 (new event queued), miss_cnt unchanged.
REQ-029 SHALL saturate miss_cnt at all-ones; no wrap.
REQ-030 Event in SERVICE SHALL queue into pending; after irq_done, FSM SHALL re-enter REQ via IDLE (one idle cycle minimum).
REQ-031 SHALL still detect events when run=0 (timer halted may hold tmr_irq).

Reset
REQ-032 On reset SHALL force state IDLE, run=0, tmr_enable=0, cmp_out=0, pending=0, irq_req=0, in_service=0, miss_cnt=0, edge register=0.
REQ-033 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction; outputs at reset values the next cycle.
REQ-034 Reset SHALL override start, cmp_wr and tmr_irq in the same cycle.

Verification
REQ-035 cmp_wr with cmp_in=0x00000010, start -> cmp_out=0x10 next cycle, tmr_enable=1; stop -> tmr_enable=0.
REQ-036 tmr_irq pulse, irq_en=1 -> pending=1, irq_req=1 one cycle later; irq_ack -> in_service=1, pending=0; irq_done -> IDLE.
REQ-037 Three events while in SERVICE -> pending=1, miss_cnt=2; after irq_done, irq_req reasserts.
REQ-038 irq_en=0, event -> pending=1, irq_req stays 0; irq_en=1 -> irq_req=1 on following cycle.
REQ-039 MISS_W=2, six dropped events -> miss_cnt=3 (saturated); tmr_irq held high 10 cycles -> one event only.
REQ-040 reset during SERVICE with pending=1, miss_cnt=5 -> all outputs zero next cycle, FSM IDLE.
